wide_add_sequencer: RTL

- Multi-cycle sequencer computing an N-word-wide add or subtract by reusing one 32-bit carry-bypass adder slice.
- Processes one word per cycle, least-significant word first, and chains the carry through a register.
- Uses valid/ready handshakes on both the operand and result sides.
- Sits between the operand register file and any consumer needing 64/128-bit arithmetic without a wide combinational adder.

---
 rtl/adder_pkg.sv | 18 +
 rtl/bypass_adder32_slice.sv | 39 +++
 rtl/wide_add_sequencer.sv | 107 ++++++++++
 3 files changed

// File: rtl/adder_pkg.sv
// Shared types and constants for the wide add/subtract sequencer and its adder slice.
package adder_pkg;

  localparam int DEF_W     = 32;
  localparam int DEF_WORDS = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Word index width; a single-bit index is kept even for degenerate sizes.
  function automatic int idx_width(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/bypass_adder32_slice.sv
// Combinational W-bit carry-bypass adder built from 4-bit skip groups.
module bypass_adder32_slice #(
  parameter int W = 32
) (
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic         Cin,
  output logic [W-1:0] S,
  output logic         Cout,
  output logic         overFlow
);

  localparam int GROUPS = W / 4;

  logic [W-1:0]      prop;
  logic [W-1:0]      gen;
  logic [W-1:0]      rc;          // ripple carry into each bit, restarted per group
  logic [GROUPS:0]   gc;          // carry between groups, taken from the skip mux
  logic [GROUPS-1:0] grp_ripple;

  assign prop  = A ^ B;
  assign gen   = A & B;
  assign gc[0] = Cin;

  for (genvar g = 0; g < GROUPS; g++) begin : g_grp
    assign rc[g*4] = gc[g];
    for (genvar b = 0; b < 3; b++) begin : g_bit
      assign rc[g*4+b+1] = gen[g*4+b] | (prop[g*4+b] & rc[g*4+b]);
    end
    assign grp_ripple[g] = gen[g*4+3] | (prop[g*4+3] & rc[g*4+3]);
    // When every bit of the group propagates, the group carry-in bypasses the ripple.
    assign gc[g+1] = (&prop[g*4 +: 4]) ? gc[g] : grp_ripple[g];
  end

  assign S        = prop ^ rc;
  assign Cout     = gc[GROUPS];
  assign overFlow = rc[W-1] ^ Cout;

endmodule

// File: rtl/wide_add_sequencer.sv
// Word-serial WORDS*W-bit add/subtract through one shared W-bit bypass adder slice,
// least-significant word first, with valid/ready on both operand and result sides.
module wide_add_sequencer
  import adder_pkg::*;
#(
  parameter int W     = DEF_W,
  parameter int WORDS = DEF_WORDS
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [W*WORDS-1:0] A,
  input  logic [W*WORDS-1:0] B,
  input  logic               Cin,
  input  logic               Sub,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [W*WORDS-1:0] S,
  output logic               Cout,
  output logic               overFlow
);

  localparam int N  = W * WORDS;
  localparam int IW = idx_width(WORDS);
  localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

  state_t        state, state_next;
  logic [N-1:0]  a_reg, b_reg;
  logic          sub_reg;
  logic          carry_reg;
  logic [IW-1:0] idx;

  logic [W-1:0]  a_word, b_word, sum_word;
  logic          slice_cout, slice_ovf;
  logic          accept, last_word;

  assign accept    = in_valid & in_ready;
  assign last_word = (idx == LAST_IDX);
  assign a_word    = a_reg[idx*W +: W];
  assign b_word    = sub_reg ? ~b_reg[idx*W +: W] : b_reg[idx*W +: W];

  bypass_adder32_slice #(.W(W)) u_slice (
    .A        (a_word),
    .B        (b_word),
    .Cin      (carry_reg),
    .S        (sum_word),
    .Cout     (slice_cout),
    .overFlow (slice_ovf)
  );

  // NOTE: state elements use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = RUN;
      end
      RUN: begin
        if (last_word) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg     <= '0;
      b_reg     <= '0;
      sub_reg   <= 1'b0;
      carry_reg <= 1'b0;
      idx       <= '0;
      S         <= '0;
      Cout      <= 1'b0;
      overFlow  <= 1'b0;
    end else if (accept) begin
      a_reg     <= A;
      b_reg     <= B;
      sub_reg   <= Sub;
      carry_reg <= Sub ? 1'b1 : Cin;
      idx       <= '0;
    end else if (state == RUN) begin
      S[idx*W +: W] <= sum_word;
      carry_reg     <= slice_cout;
      if (last_word) begin
        Cout     <= slice_cout;
        overFlow <= slice_ovf;
      end else begin
        idx <= idx + 1'b1;
      end
    end
  end

endmodule
